// File: rtl/axil_demux_n.sv
// 1-to-NUM_SLV AXI4-Lite demultiplexer with base/mask address decode,
// an internal DECERR responder for unmapped addresses and a saturating error count.
module axil_demux_n #(
  parameter int unsigned                       ADDR_WIDTH   = 32,
  parameter int unsigned                       DATA_WIDTH   = 32,
  parameter int unsigned                       NUM_SLV      = 4,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0]     SLV_BASE     = {NUM_SLV{32'h0}},
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0]     SLV_MASK     = {NUM_SLV{32'hFFFF_F000}},
  parameter logic [DATA_WIDTH-1:0]             DECERR_RDATA = 32'hDEAD_BEEF,
  parameter int unsigned                       CNT_WIDTH    = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          s_aw_valid,
  output logic                          s_aw_ready,
  input  logic [ADDR_WIDTH-1:0]         s_aw_addr,
  input  logic [2:0]                    s_aw_prot,
  input  logic                          s_w_valid,
  output logic                          s_w_ready,
  input  logic [DATA_WIDTH-1:0]         s_w_data,
  input  logic [DATA_WIDTH/8-1:0]       s_w_strb,
  output logic                          s_b_valid,
  input  logic                          s_b_ready,
  output logic [1:0]                    s_b_resp,
  input  logic                          s_ar_valid,
  output logic                          s_ar_ready,
  input  logic [ADDR_WIDTH-1:0]         s_ar_addr,
  input  logic [2:0]                    s_ar_prot,
  output logic                          s_r_valid,
  input  logic                          s_r_ready,
  output logic [DATA_WIDTH-1:0]         s_r_data,
  output logic [1:0]                    s_r_resp,
  output logic [NUM_SLV-1:0]            m_aw_valid,
  input  logic [NUM_SLV-1:0]            m_aw_ready,
  output logic [ADDR_WIDTH-1:0]         m_aw_addr,
  output logic [2:0]                    m_aw_prot,
  output logic [NUM_SLV-1:0]            m_w_valid,
  input  logic [NUM_SLV-1:0]            m_w_ready,
  output logic [DATA_WIDTH-1:0]         m_w_data,
  output logic [DATA_WIDTH/8-1:0]       m_w_strb,
  input  logic [NUM_SLV-1:0]            m_b_valid,
  output logic [NUM_SLV-1:0]            m_b_ready,
  input  logic [NUM_SLV*2-1:0]          m_b_resp,
  output logic [NUM_SLV-1:0]            m_ar_valid,
  input  logic [NUM_SLV-1:0]            m_ar_ready,
  output logic [ADDR_WIDTH-1:0]         m_ar_addr,
  output logic [2:0]                    m_ar_prot,
  input  logic [NUM_SLV-1:0]            m_r_valid,
  output logic [NUM_SLV-1:0]            m_r_ready,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] m_r_data,
  input  logic [NUM_SLV*2-1:0]          m_r_resp,
  output logic [CNT_WIDTH-1:0]          o_decerr_cnt
);

  localparam int unsigned SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP}        w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_t;

  // Returns {err, sel}; scanning upward and stopping at the first hit gives lowest-index priority.
  function automatic logic [SEL_W:0] f_decode(input logic [ADDR_WIDTH-1:0] a);
    logic             err;
    logic [SEL_W-1:0] sel;
    err = 1'b1;
    sel = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (err && ((a & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        err = 1'b0;
        sel = SEL_W'(i);
      end
    end
    return {err, sel};
  endfunction

  w_state_t                r_wstate;
  r_state_t                r_rstate;
  logic                    r_aw_rdy, r_ar_rdy;
  logic [NUM_SLV-1:0]      r_m_aw_valid, r_m_ar_valid;
  logic [ADDR_WIDTH-1:0]   r_aw_addr, r_ar_addr;
  logic [2:0]              r_aw_prot, r_ar_prot;
  logic [SEL_W-1:0]        r_wsel, r_rsel;
  logic                    r_werr, r_aw_done, r_w_done;
  logic [CNT_WIDTH-1:0]    r_cnt;

  logic [SEL_W:0]          w_aw_dec, w_ar_dec;
  logic                    w_aw_hs, w_ar_hs, w_maw_hs, w_mar_hs, w_w_hs, w_b_hs, w_r_hs;
  logic                    w_aw_err, w_ar_err;
  logic [CNT_WIDTH:0]      w_cnt_sum;

  assign w_aw_dec = f_decode(s_aw_addr);
  assign w_ar_dec = f_decode(s_ar_addr);
  assign w_aw_hs  = s_aw_valid & r_aw_rdy;
  assign w_ar_hs  = s_ar_valid & r_ar_rdy;
  assign w_maw_hs = |(r_m_aw_valid & m_aw_ready);
  assign w_mar_hs = |(r_m_ar_valid & m_ar_ready);
  assign w_w_hs   = s_w_valid & s_w_ready;
  assign w_b_hs   = s_b_valid & s_b_ready;
  assign w_r_hs   = s_r_valid & s_r_ready;
  assign w_aw_err = w_aw_hs & w_aw_dec[SEL_W];
  assign w_ar_err = w_ar_hs & w_ar_dec[SEL_W];

  assign s_aw_ready   = r_aw_rdy;
  assign s_ar_ready   = r_ar_rdy;
  assign m_aw_valid   = r_m_aw_valid;
  assign m_ar_valid   = r_m_ar_valid;
  assign m_aw_addr    = r_aw_addr;
  assign m_aw_prot    = r_aw_prot;
  assign m_ar_addr    = r_ar_addr;
  assign m_ar_prot    = r_ar_prot;
  assign m_w_data     = s_w_data;
  assign m_w_strb     = s_w_strb;
  assign o_decerr_cnt = r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wstate     <= W_IDLE;
      r_aw_rdy     <= 1'b0;
      r_m_aw_valid <= '0;
      r_aw_addr    <= '0;
      r_aw_prot    <= '0;
      r_wsel       <= '0;
      r_werr       <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_rdy     <= 1'b0;
            r_aw_addr    <= s_aw_addr;
            r_aw_prot    <= s_aw_prot;
            r_wsel       <= w_aw_dec[SEL_W-1:0];
            r_werr       <= w_aw_dec[SEL_W];
            r_m_aw_valid <= w_aw_dec[SEL_W] ? '0 : (NUM_SLV'(1) << w_aw_dec[SEL_W-1:0]);
            r_aw_done    <= w_aw_dec[SEL_W];
            r_w_done     <= 1'b0;
            r_wstate     <= W_FWD;
          end else begin
            r_aw_rdy <= 1'b1;
          end
        end
        W_FWD: begin
          if (w_maw_hs) begin
            r_m_aw_valid <= '0;
            r_aw_done    <= 1'b1;
          end
          if (w_w_hs) r_w_done <= 1'b1;
          if ((r_aw_done | w_maw_hs) & (r_w_done | w_w_hs)) r_wstate <= W_RESP;
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_wstate <= W_IDLE;
            r_aw_rdy <= 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    s_w_ready = 1'b0;
    m_w_valid = '0;
    s_b_valid = 1'b0;
    s_b_resp  = 2'b00;
    m_b_ready = '0;
    if (r_wstate == W_FWD && !r_w_done) begin
      if (r_werr) begin
        s_w_ready = 1'b1;
      end else begin
        s_w_ready         = m_w_ready[r_wsel];
        m_w_valid[r_wsel] = s_w_valid;
      end
    end
    if (r_wstate == W_RESP) begin
      if (r_werr) begin
        s_b_valid = 1'b1;
        s_b_resp  = 2'b11;
      end else begin
        s_b_valid         = m_b_valid[r_wsel];
        s_b_resp          = m_b_resp[r_wsel*2 +: 2];
        m_b_ready[r_wsel] = s_b_ready;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rstate     <= R_IDLE;
      r_ar_rdy     <= 1'b0;
      r_m_ar_valid <= '0;
      r_ar_addr    <= '0;
      r_ar_prot    <= '0;
      r_rsel       <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_ar_rdy  <= 1'b0;
            r_ar_addr <= s_ar_addr;
            r_ar_prot <= s_ar_prot;
            r_rsel    <= w_ar_dec[SEL_W-1:0];
            if (w_ar_dec[SEL_W]) begin
              r_rstate <= R_ERR;
            end else begin
              r_m_ar_valid <= NUM_SLV'(1) << w_ar_dec[SEL_W-1:0];
              r_rstate     <= R_ADDR;
            end
          end else begin
            r_ar_rdy <= 1'b1;
          end
        end
        R_ADDR: begin
          if (w_mar_hs) begin
            r_m_ar_valid <= '0;
            r_rstate     <= R_DATA;
          end
        end
        R_DATA, R_ERR: begin
          if (w_r_hs) begin
            r_rstate <= R_IDLE;
            r_ar_rdy <= 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    s_r_valid = 1'b0;
    s_r_data  = '0;
    s_r_resp  = 2'b00;
    m_r_ready = '0;
    if (r_rstate == R_DATA) begin
      s_r_valid         = m_r_valid[r_rsel];
      s_r_data          = m_r_data[r_rsel*DATA_WIDTH +: DATA_WIDTH];
      s_r_resp          = m_r_resp[r_rsel*2 +: 2];
      m_r_ready[r_rsel] = s_r_ready;
    end else if (r_rstate == R_ERR) begin
      s_r_valid = 1'b1;
      s_r_data  = DECERR_RDATA;
      s_r_resp  = 2'b11;
    end
  end

  // One extra headroom bit catches both single and double increments past all-ones.
  assign w_cnt_sum = {1'b0, r_cnt} + (CNT_WIDTH+1)'(w_aw_err) + (CNT_WIDTH+1)'(w_ar_err);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= w_cnt_sum[CNT_WIDTH] ? '1 : w_cnt_sum[CNT_WIDTH-1:0];
  end

endmodule
